// File: rtl/multicycle_controller.sv
// Control FSM for a multicycle RV32I datapath: sequences the shared memory, IR and ALU,
// one state per cycle, driving every write enable, mux select and ALU/immediate control.
module multicycle_controller #(
    parameter int unsigned STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         op,
    input  logic [2:0]         func3,
    input  logic [6:0]         func7,
    input  logic               zero,
    input  logic               branchLEG,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [2:0]         ALUControl,
    output logic [2:0]         ImmSrc,
    output logic               done,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [STATE_W-1:0] {
        StFetch   = STATE_W'(0),
        StDecode  = STATE_W'(1),
        StMemAdr  = STATE_W'(2),
        StMemRead = STATE_W'(3),
        StMemWb   = STATE_W'(4),
        StMemWr   = STATE_W'(5),
        StExecR   = STATE_W'(6),
        StExecI   = STATE_W'(7),
        StAluWb   = STATE_W'(8),
        StBranch  = STATE_W'(9),
        StJal     = STATE_W'(10),
        StJalr    = STATE_W'(11),
        StLui     = STATE_W'(12)
    } state_e;

    localparam logic [2:0] AluAdd = 3'b000, AluSub = 3'b001, AluAnd = 3'b010, AluOr = 3'b011,
                           AluXor = 3'b100, AluSlt = 3'b101, AluSltu = 3'b110;
    localparam logic [2:0] ImmI = 3'b000, ImmS = 3'b001, ImmB = 3'b010, ImmJ = 3'b011,
                           ImmU = 3'b100;

    state_e state_q, state_d;
    logic   pc_we, mem_we, ir_we, reg_we;

    // Only func7[5] matters (SUB vs ADD); the remaining bits are ignored.
    logic unused_func7;
    assign unused_func7 = ^{func7[6], func7[4:0]};

    function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  return sub ? AluSub : AluAdd;
            3'b111:  return AluAnd;
            3'b110:  return AluOr;
            3'b100:  return AluXor;
            3'b010:  return AluSlt;
            3'b011:  return AluSltu;
            default: return AluAdd;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StFetch;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = StFetch;
        pc_we      = 1'b0;
        AdrSrc     = 1'b0;
        mem_we     = 1'b0;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = AluAdd;
        ImmSrc     = ImmI;
        done       = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            StFetch: begin
                ir_we     = 1'b1;
                pc_we     = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                state_d   = StDecode;
            end
            StDecode: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    7'b0000011: begin ImmSrc = ImmI; state_d = StMemAdr; end
                    7'b0100011: begin ImmSrc = ImmS; state_d = StMemAdr; end
                    7'b0110011: state_d = StExecR;
                    7'b0010011: begin ImmSrc = ImmI; state_d = StExecI; end
                    7'b1100011: begin ImmSrc = ImmB; state_d = StBranch; end
                    7'b1101111: begin ImmSrc = ImmJ; state_d = StJal; end
                    7'b1100111: begin ImmSrc = ImmI; state_d = StJalr; end
                    7'b0110111: begin ImmSrc = ImmU; state_d = StLui; end
                    default:    illegal = 1'b1;
                endcase
            end
            StMemAdr: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = op[5] ? ImmS : ImmI;
                state_d = op[5] ? StMemWr : StMemRead;
            end
            StMemRead: begin
                AdrSrc  = 1'b1;
                state_d = StMemWb;
            end
            StMemWb: begin
                ResultSrc = 2'b01;
                reg_we    = 1'b1;
                done      = 1'b1;
            end
            StMemWr: begin
                AdrSrc = 1'b1;
                mem_we = 1'b1;
                done   = 1'b1;
            end
            StExecR: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_dec(func3, func7[5]);
                state_d    = StAluWb;
            end
            StExecI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_dec(func3, 1'b0);
                state_d    = StAluWb;
            end
            StAluWb: begin
                reg_we = 1'b1;
                done   = 1'b1;
            end
            StBranch: begin
                ALUSrcA = 2'b10;
                done    = 1'b1;
                case (func3)
                    3'b000:  begin ALUControl = AluSub; pc_we = zero;       end
                    3'b001:  begin ALUControl = AluSub; pc_we = ~zero;      end
                    3'b100:  begin ALUControl = AluSlt; pc_we = branchLEG;  end
                    3'b101:  begin ALUControl = AluSlt; pc_we = ~branchLEG; end
                    default: ;
                endcase
            end
            // PC takes the target held in ALUOut while ALU forms the link address.
            StJal: begin
                pc_we   = 1'b1;
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                state_d = StAluWb;
            end
            StJalr: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = StJal;
            end
            StLui: begin
                ImmSrc    = ImmU;
                ResultSrc = 2'b11;
                reg_we    = 1'b1;
                done      = 1'b1;
            end
            default: ;
        endcase
    end

    // Write enables are held off for the whole reset pulse, not just until the next edge.
    assign PCWrite  = pc_we & ~rst;
    assign MemWrite = mem_we & ~rst;
    assign IRWrite  = ir_we & ~rst;
    assign RegWrite = reg_we & ~rst;
    assign state    = state_q;

endmodule
